// File: rtl/async_req_pkg.sv
// Shared constants and FSM state type for the asynchronous request scheduler.
package async_req_pkg;

  // Shallowest synchronizer chain that still resolves metastability.
  localparam int MIN_STAGES = 2;
  // Largest number of request lines the scheduler supports.
  localparam int MAX_REQ    = 16;

  // Output handshake states: waiting for work, or holding an offered event.
  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_OFFER = 1'b1
  } state_e;

endpackage

// File: rtl/async_req_scheduler_sync.sv
// Multi-flop level synchronizer; every flop clears on reset so the output starts low.
module synchronizer #(
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic rstn,
  input  logic async_sig_i,
  output logic sync_sig_o
);

  logic [STAGES-1:0] chain_q;

  // Shift the raw level through the chain; the last flop is the usable copy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chain_q <= {STAGES{1'b0}};
    end else begin
      chain_q <= {chain_q[STAGES-2:0], async_sig_i};
    end
  end

  assign sync_sig_o = chain_q[STAGES-1];

endmodule

// File: rtl/async_req_scheduler.sv
// Brings NUM_REQ asynchronous request lines into the clk domain, turns each rising
// edge into a pending flag and hands pending lines to one consumer in round-robin order.
module async_req_scheduler
  import async_req_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int STAGES  = 3,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_REQ-1:0] async_req_i,
  output logic               evt_valid_o,
  output logic [ID_W-1:0]    evt_id_o,
  input  logic               evt_ready_i,
  output logic [NUM_REQ-1:0] overflow_o,
  input  logic               ovf_clr_i
);

  logic [NUM_REQ-1:0] sync_s;
  logic [NUM_REQ-1:0] prev_q;
  logic [NUM_REQ-1:0] rise_s;
  logic [NUM_REQ-1:0] pending_q;
  logic [NUM_REQ-1:0] pending_d;
  logic [NUM_REQ-1:0] overflow_q;
  logic [NUM_REQ-1:0] overflow_d;
  logic [NUM_REQ-1:0] grant_s;
  logic [NUM_REQ-1:0] ovf_set_s;
  logic               accept_s;
  logic [ID_W-1:0]    pick_s;
  state_e             state_q;
  logic               evt_valid_q;
  logic [ID_W-1:0]    evt_id_q;
  logic [ID_W-1:0]    rr_ptr_q;

  // First set bit of req at or above ptr, wrapping around modulo NUM_REQ.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] sel;
    logic            found;
    int              idx;
    sel   = {ID_W{1'b0}};
    found = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      idx = (int'(ptr) + j) % NUM_REQ;
      if (!found && req[idx]) begin
        sel   = ID_W'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // Successor index with wrap at NUM_REQ (NUM_REQ need not be a power of two).
  function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] id);
    if (int'(id) >= NUM_REQ - 1) begin
      return {ID_W{1'b0}};
    end else begin
      return id + ID_W'(1);
    end
  endfunction

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_sync
    synchronizer #(.STAGES(STAGES)) u_sync (
      .clk        (clk),
      .rstn       (rstn),
      .async_sig_i(async_req_i[gi]),
      .sync_sig_o (sync_s[gi])
    );
  end

  assign rise_s   = sync_s & ~prev_q;
  assign accept_s = (state_q == S_OFFER) & evt_ready_i;
  assign pick_s   = rr_pick(pending_q, rr_ptr_q);

  // Pending/overflow next state: a rise coinciding with acceptance re-arms the line
  // instead of counting as an overflow; an overflow set beats a same-cycle clear.
  always_comb begin
    grant_s = {NUM_REQ{1'b0}};
    if (accept_s) begin
      grant_s[evt_id_q] = 1'b1;
    end else begin
      grant_s = {NUM_REQ{1'b0}};
    end
    pending_d = rise_s | (pending_q & ~grant_s);
    ovf_set_s = rise_s & pending_q & ~grant_s;
    if (ovf_clr_i) begin
      overflow_d = ovf_set_s;
    end else begin
      overflow_d = overflow_q | ovf_set_s;
    end
  end

  // Edge history, pending flags and sticky overflow bits.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_q     <= {NUM_REQ{1'b0}};
      pending_q  <= {NUM_REQ{1'b0}};
      overflow_q <= {NUM_REQ{1'b0}};
    end else begin
      prev_q     <= sync_s;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  // Offer FSM: pick only in IDLE, hold id/valid through OFFER, advance pointer on transfer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      evt_valid_q <= 1'b0;
      evt_id_q    <= {ID_W{1'b0}};
      rr_ptr_q    <= {ID_W{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|pending_q) begin
            evt_id_q    <= pick_s;
            evt_valid_q <= 1'b1;
            state_q     <= S_OFFER;
          end
        end
        S_OFFER: begin
          if (evt_ready_i) begin
            evt_valid_q <= 1'b0;
            rr_ptr_q    <= rr_next(evt_id_q);
            state_q     <= S_IDLE;
          end
        end
        default: begin
          evt_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign evt_valid_o = evt_valid_q;
  assign evt_id_o    = evt_id_q;
  assign overflow_o  = overflow_q;

endmodule
